cpu_program_loader: RTL and testbench

Upstream feeder for the cpu top. Accepts a 32-bit valid/ready word stream and writes it into instruction memory, then data memory, through the cpu external ports (addr_ext/wen_ext/wdata_ext and addr_ext_2/wen_ext_2/wdata_ext_2). It then drives cpu enable for a programmed number of cycles and reports done. It replaces testbench-driven memory preload for on-chip bring-up.

---
 rtl/cpu_program_loader.sv | 161 ++++++++++++++++
 tb/tb_cpu_program_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_loader.sv
// Streams a program image into cpu instruction and data memory, then runs the cpu for a set number of cycles.
// Write strobes trail the accepted beat by one cycle; s_valid low stalls the current load phase with no timeout.
module cpu_program_loader #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic [IMEM_ADDR_W:0]   imem_words,
  input  logic [DMEM_ADDR_W:0]   dmem_words,
  input  logic [31:0]            run_cycles,
  input  logic [31:0]            s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [63:0]            addr_ext,
  output logic                   wen_ext,
  output logic                   ren_ext,
  output logic [31:0]            wdata_ext,
  output logic [63:0]            addr_ext_2,
  output logic                   wen_ext_2,
  output logic                   ren_ext_2,
  output logic [63:0]            wdata_ext_2,
  output logic                   cpu_enable,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            cycle_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_I    = 3'd1,
    LOAD_D_LO = 3'd2,
    LOAD_D_HI = 3'd3,
    RUN       = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [IMEM_ADDR_W:0] I_ONE = {{IMEM_ADDR_W{1'b0}}, 1'b1};
  localparam logic [DMEM_ADDR_W:0] D_ONE = {{DMEM_ADDR_W{1'b0}}, 1'b1};
  localparam logic [IMEM_ADDR_W:0] I_MAX = {1'b1, {IMEM_ADDR_W{1'b0}}};
  localparam logic [DMEM_ADDR_W:0] D_MAX = {1'b1, {DMEM_ADDR_W{1'b0}}};

  state_t                 state, state_nxt;
  logic [IMEM_ADDR_W:0]   i_words, i_idx;
  logic [DMEM_ADDR_W:0]   d_words, d_idx;
  logic [31:0]            run_len;
  logic [31:0]            lo_word;
  logic                   run_started;

  logic accept, start_ok, cfg_bad, i_last, d_last;

  assign s_ready   = (state == LOAD_I) || (state == LOAD_D_LO) || (state == LOAD_D_HI);
  assign accept    = s_valid && s_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign cfg_bad   = (imem_words > I_MAX) || (dmem_words > D_MAX);
  assign i_last    = ((i_idx + I_ONE) == i_words);
  assign d_last    = ((d_idx + D_ONE) == d_words);

  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  // The first RUN cycle is a gap so the final memory write lands before the cpu starts.
  assign cpu_enable = (state == RUN) && run_started;
  assign ren_ext    = 1'b0;
  assign ren_ext_2  = 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (cfg_bad)                 state_nxt = DONE;
          else if (imem_words != '0)   state_nxt = LOAD_I;
          else if (dmem_words != '0)   state_nxt = LOAD_D_LO;
          else if (run_cycles != 32'd0) state_nxt = RUN;
          else                         state_nxt = DONE;
        end
      end
      LOAD_I: begin
        if (accept && i_last) begin
          if (d_words != '0)          state_nxt = LOAD_D_LO;
          else if (run_len != 32'd0)  state_nxt = RUN;
          else                        state_nxt = DONE;
        end
      end
      LOAD_D_LO: begin
        if (accept) state_nxt = LOAD_D_HI;
      end
      LOAD_D_HI: begin
        if (accept) begin
          if (!d_last)                state_nxt = LOAD_D_LO;
          else if (run_len != 32'd0)  state_nxt = RUN;
          else                        state_nxt = DONE;
        end
      end
      RUN: begin
        if (run_started && ((cycle_count + 32'd1) == run_len)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      i_words     <= '0;
      d_words     <= '0;
      run_len     <= '0;
      i_idx       <= '0;
      d_idx       <= '0;
      lo_word     <= '0;
      run_started <= 1'b0;
      wen_ext     <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_ext_2   <= 1'b0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
      error       <= 1'b0;
      cycle_count <= '0;
    end else begin
      state     <= state_nxt;
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;

      if (start_ok) begin
        i_words     <= imem_words;
        d_words     <= dmem_words;
        run_len     <= run_cycles;
        i_idx       <= '0;
        d_idx       <= '0;
        cycle_count <= '0;
        run_started <= 1'b0;
        error       <= cfg_bad;
      end

      if ((state == LOAD_I) && accept) begin
        wen_ext   <= 1'b1;
        addr_ext  <= {{(64-IMEM_ADDR_W-3){1'b0}}, i_idx, 2'b00};
        wdata_ext <= s_data;
        i_idx     <= i_idx + I_ONE;
      end

      if ((state == LOAD_D_LO) && accept) lo_word <= s_data;

      if ((state == LOAD_D_HI) && accept) begin
        wen_ext_2   <= 1'b1;
        addr_ext_2  <= {{(64-DMEM_ADDR_W-4){1'b0}}, d_idx, 3'b000};
        wdata_ext_2 <= {s_data, lo_word};
        d_idx       <= d_idx + D_ONE;
      end

      if (state == RUN) begin
        if (!run_started)                run_started <= 1'b1;
        else if (cycle_count != run_len) cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader: loads, stalls, config error, ignored start, reset mid-load.
module tb_cpu_program_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  imem_words = '0;
  logic [10:0] dmem_words = '0;
  logic [31:0] run_cycles = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] wdata_ext, cycle_count;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic        cpu_enable, busy, done, error;

  always #5 clk = ~clk;

  cpu_program_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_words(imem_words), .dmem_words(dmem_words), .run_cycles(run_cycles),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error), .cycle_count(cycle_count)
  );

  int total = 0;
  int bad = 0;

  // Write/enable recorder, sampled mid-cycle.
  logic [63:0] w_addr[$];
  logic [63:0] w_data[$];
  int          w_kind[$];
  int          en_cnt = 0;
  int          ov_cnt = 0;

  always @(negedge clk) begin
    if (wen_ext) begin
      w_addr.push_back(addr_ext); w_data.push_back({32'd0, wdata_ext}); w_kind.push_back(0);
    end
    if (wen_ext_2) begin
      w_addr.push_back(addr_ext_2); w_data.push_back(wdata_ext_2); w_kind.push_back(1);
    end
    if (cpu_enable) en_cnt++;
    if (cpu_enable && (wen_ext || wen_ext_2)) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int i, input int d, input int r);
    imem_words = 10'(i); dmem_words = 11'(d); run_cycles = 32'(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    s_data = d; s_valid = 1'b1;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    chk("send_ready", s_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 500) begin @(negedge clk); n++; end
    chk("done_timeout", done, 1);
  endtask

  task automatic check_write(input string tag, input int idx, input int kind,
                             input logic [63:0] addr, input logic [63:0] data);
    if (idx < w_addr.size()) begin
      chk({tag, "_kind"}, 64'(w_kind[idx]), 64'(kind));
      chk({tag, "_addr"}, w_addr[idx], addr);
      chk({tag, "_data"}, w_data[idx], data);
    end else begin
      chk({tag, "_missing"}, 64'(w_addr.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int base, e0;
    int rdy_seen;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_sready", s_ready, 0);
    chk("rst_wen", wen_ext, 0);
    chk("rst_cpuen", cpu_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    arst_n = 1'b1;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_err", error, 0);
    chk("idle_cc", cycle_count, 0);
    chk("idle_addr", addr_ext, 0);

    // Three instruction words, run 5
    base = w_addr.size(); e0 = en_cnt;
    pulse_start(3, 0, 5);
    send(32'h00000013); send(32'h00100093); send(32'h00208133);
    s_valid = 1'b0;
    wait_done();
    chk("t1_nwr", 64'(w_addr.size() - base), 3);
    check_write("t1_w0", base + 0, 0, 64'd0, 64'h00000013);
    check_write("t1_w1", base + 1, 0, 64'd4, 64'h00100093);
    check_write("t1_w2", base + 2, 0, 64'd8, 64'h00208133);
    chk("t1_en", 64'(en_cnt - e0), 5);
    chk("t1_cc", cycle_count, 5);
    chk("t1_busy", busy, 0);
    chk("t1_err", error, 0);
    chk("t1_hold_addr", addr_ext, 64'd8);
    chk("t1_hold_data", wdata_ext, 32'h00208133);

    // One instruction word plus two data words
    base = w_addr.size(); e0 = en_cnt;
    pulse_start(1, 2, 3);
    send(32'hDEADBEEF); send(32'h11111111); send(32'h22222222);
    send(32'h33333333); send(32'h44444444);
    s_valid = 1'b0;
    wait_done();
    chk("t2_nwr", 64'(w_addr.size() - base), 3);
    check_write("t2_i0", base + 0, 0, 64'd0, 64'hDEADBEEF);
    check_write("t2_d0", base + 1, 1, 64'd0, 64'h2222222211111111);
    check_write("t2_d1", base + 2, 1, 64'd8, 64'h4444444433333333);
    chk("t2_en", 64'(en_cnt - e0), 3);
    chk("t2_cc", cycle_count, 3);

    // Stall in LOAD_I: valid 1-0-0-1
    base = w_addr.size();
    pulse_start(2, 0, 1);
    send(32'hAAAA0001);
    s_valid = 1'b0;
    @(negedge clk);
    chk("t3_stall_wen", wen_ext, 0);
    chk("t3_stall_rdy", s_ready, 1);
    chk("t3_stall_addr", addr_ext, 64'd0);
    @(negedge clk);
    chk("t3_stall2_wen", wen_ext, 0);
    send(32'hAAAA0002);
    s_valid = 1'b0;
    wait_done();
    chk("t3_nwr", 64'(w_addr.size() - base), 2);
    check_write("t3_w0", base + 0, 0, 64'd0, 64'hAAAA0001);
    check_write("t3_w1", base + 1, 0, 64'd4, 64'hAAAA0002);

    // Oversized instruction count
    base = w_addr.size();
    pulse_start(513, 0, 3);
    chk("t4_err", error, 1);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    rdy_seen = 0;
    s_valid = 1'b1; s_data = 32'h5555AAAA;
    for (int k = 0; k < 5; k++) begin
      if (s_ready) rdy_seen++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("t4_rdy_seen", 64'(rdy_seen), 0);
    chk("t4_nwr", 64'(w_addr.size() - base), 0);
    chk("t4_err_sticky", error, 1);

    // start during RUN is ignored
    base = w_addr.size(); e0 = en_cnt;
    pulse_start(0, 0, 6);
    chk("t5_err_clr", error, 0);
    repeat (3) @(negedge clk);
    chk("t5_run_en", cpu_enable, 1);
    imem_words = 10'd1; run_cycles = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("t5_en", 64'(en_cnt - e0), 6);
    chk("t5_cc", cycle_count, 6);
    chk("t5_nwr", 64'(w_addr.size() - base), 0);

    // Reset during LOAD_D_HI, then reload
    pulse_start(0, 1, 2);
    send(32'hCAFE0000);
    s_valid = 1'b0;
    chk("t6_busy", busy, 1);
    chk("t6_rdy", s_ready, 1);
    arst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rdy", s_ready, 0);
    chk("t6_rst_wdata", wdata_ext, 0);
    chk("t6_rst_wdata2", wdata_ext_2, 0);
    chk("t6_rst_addr2", addr_ext_2, 0);
    chk("t6_rst_wen2", wen_ext_2, 0);
    chk("t6_rst_en", cpu_enable, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    base = w_addr.size(); e0 = en_cnt;
    pulse_start(1, 1, 2);
    send(32'h12345678); send(32'h0BADF00D); send(32'hFEEDFACE);
    s_valid = 1'b0;
    wait_done();
    chk("t6_nwr", 64'(w_addr.size() - base), 2);
    check_write("t6_i0", base + 0, 0, 64'd0, 64'h12345678);
    check_write("t6_d0", base + 1, 1, 64'd0, 64'hFEEDFACE0BADF00D);
    chk("t6_en", 64'(en_cnt - e0), 2);
    chk("t6_cc", cycle_count, 2);

    chk("no_strobe_with_enable", 64'(ov_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
